// File: rtl/fitness_timer_pkg.sv
// Shared definitions for the fitness interval timer: phase encoding, FSM state type and
// the width used for all second counts.
package fitness_timer_pkg;

  localparam int unsigned SecW = 8;

  localparam logic [1:0] PhaseIdle = 2'd0;
  localparam logic [1:0] PhaseWork = 2'd1;
  localparam logic [1:0] PhaseRest = 2'd2;
  localparam logic [1:0] PhaseDone = 2'd3;

  // State values double as the externally visible phase code.
  typedef enum logic [1:0] {
    StIdle = PhaseIdle,
    StWork = PhaseWork,
    StRest = PhaseRest,
    StDone = PhaseDone
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-second tick. Counts 0..TICKS_PER_SEC-1 while enabled and
// holds its value while disabled, so a frozen countdown resumes mid-second.
module tick_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICKS_PER_SEC);
  localparam logic [CntW-1:0] Terminal = CntW'(TICKS_PER_SEC - 1);

  logic [CntW-1:0] cnt_q;

  // Tick is the terminal count of an enabled cycle.
  always_comb begin
    tick = enable && (cnt_q == Terminal);
  end

  // Count register, wrapping at the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/interval_countdown.sv
// Interval (work/rest) countdown timer. Runs ROUNDS work phases of a latched length,
// separated by REST_SEC rest phases, with pause/resume and abort. All outputs registered.
module interval_countdown
  import fitness_timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned REST_SEC      = 10,
  parameter int unsigned ROUNDS        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SecW-1:0] duration_in,
  input  logic            start,
  input  logic            pause,
  input  logic            abort,
  output logic [SecW-1:0] remaining,
  output logic [1:0]      phase,
  output logic [3:0]      round_cnt,
  output logic            paused,
  output logic            beep
);

  localparam logic [SecW-1:0] RestLoad  = SecW'(REST_SEC);
  localparam logic [3:0]      RoundsMax = 4'(ROUNDS);

  state_t          state_q, state_d;
  logic [SecW-1:0] remaining_q, remaining_d;
  logic [SecW-1:0] work_len_q, work_len_d;
  logic [3:0]      round_q, round_d;
  logic            paused_q, paused_d;
  logic            beep_q, beep_d;

  logic running, start_go, presc_en, presc_rst, tick;

  // Prescaler control: the accepting cycle counts as the first cycle of the first second,
  // and abort clears any partial second so the next session starts clean.
  always_comb begin
    running   = ((state_q == StWork) || (state_q == StRest)) && !paused_q;
    start_go  = ((state_q == StIdle) || (state_q == StDone)) && start &&
                (duration_in != '0) && !abort;
    presc_en  = running || start_go;
    presc_rst = rst || abort;
  end

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .rst   (presc_rst),
    .enable(presc_en),
    .tick  (tick)
  );

  // Next-state logic; priority is abort > pause > tick > start.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    work_len_d  = work_len_q;
    round_d     = round_q;
    paused_d    = paused_q;
    beep_d      = 1'b0;
    if (abort) begin
      state_d     = StIdle;
      remaining_d = '0;
      round_d     = '0;
      paused_d    = 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_go) begin
            state_d     = StWork;
            work_len_d  = duration_in;
            remaining_d = duration_in;
            round_d     = 4'd1;
            paused_d    = 1'b0;
            beep_d      = 1'b1;
          end
        end
        StWork, StRest: begin
          if (pause) begin
            // A pause coinciding with a tick swallows that tick.
            paused_d = !paused_q;
          end else if (running && tick) begin
            if (remaining_q > 8'd1) begin
              remaining_d = remaining_q - 8'd1;
            end else begin
              beep_d = 1'b1;
              if (state_q == StRest) begin
                state_d     = StWork;
                round_d     = round_q + 4'd1;
                remaining_d = work_len_q;
              end else if (round_q == RoundsMax) begin
                state_d     = StDone;
                remaining_d = '0;
              end else begin
                state_d     = StRest;
                remaining_d = RestLoad;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      work_len_q  <= '0;
      round_q     <= '0;
      paused_q    <= 1'b0;
      beep_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      work_len_q  <= work_len_d;
      round_q     <= round_d;
      paused_q    <= paused_d;
      beep_q      <= beep_d;
    end
  end

  assign remaining = remaining_q;
  assign phase     = state_q;
  assign round_cnt = round_q;
  assign paused    = paused_q;
  assign beep      = beep_q;

endmodule

// File: tb/tb_interval_countdown.sv
// Self-checking bench for interval_countdown: a cycle-level reference model pushes the
// expected output word each cycle; it is popped and compared after the clock edge.
// Spot checks at fixed cycles pin the model to the documented session timeline.
module tb_interval_countdown;

  localparam int unsigned Tps    = 4;
  localparam int unsigned RestS  = 2;
  localparam int unsigned Rounds = 2;

  logic       clk = 1'b0;
  logic       rst, start, pause, abort;
  logic [7:0] duration_in, remaining;
  logic [1:0] phase;
  logic [3:0] round_cnt;
  logic       paused, beep;

  always #5 clk = ~clk;

  interval_countdown #(
    .TICKS_PER_SEC(Tps),
    .REST_SEC     (RestS),
    .ROUNDS       (Rounds)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .duration_in(duration_in),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .remaining  (remaining),
    .phase      (phase),
    .round_cnt  (round_cnt),
    .paused     (paused),
    .beep       (beep)
  );

  int total = 0;
  int bad   = 0;
  int cnum  = 0;
  logic [7:0]  cur_dur = 8'd0;
  logic [15:0] exp_q[$];

  // Reference model state.
  logic [1:0] m_ph;
  logic [7:0] m_rem, m_len;
  logic [3:0] m_rnd;
  logic       m_pau, m_beep;
  int         m_left;  // enabled cycles until the next tick, inclusive

  // Output word: {phase, remaining, round_cnt, paused, beep}.
  function automatic logic [15:0] obs();
    return {phase, remaining, round_cnt, paused, beep};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got ph=%0d rem=%0d rnd=%0d pau=%0d beep=%0d want ph=%0d rem=%0d rnd=%0d pau=%0d beep=%0d",
               tag, got[15:14], got[13:6], got[5:2], got[1], got[0],
               want[15:14], want[13:6], want[5:2], want[1], want[0]);
    end
  endtask

  task automatic model(input logic r, input logic s, input logic p, input logic a,
                       input logic [7:0] d);
    logic tk;
    m_beep = 1'b0;
    if (r) begin
      m_ph = 2'd0; m_rem = 8'd0; m_len = 8'd0; m_rnd = 4'd0; m_pau = 1'b0; m_left = Tps;
    end else if (a) begin
      m_ph = 2'd0; m_rem = 8'd0; m_rnd = 4'd0; m_pau = 1'b0; m_left = Tps;
    end else if (m_ph == 2'd1 || m_ph == 2'd2) begin
      tk = 1'b0;
      if (!m_pau) begin
        tk     = (m_left == 1);
        m_left = tk ? Tps : m_left - 1;
      end
      if (p) begin
        m_pau = !m_pau;
      end else if (tk) begin
        if (m_rem > 8'd1) begin
          m_rem = m_rem - 8'd1;
        end else begin
          m_beep = 1'b1;
          if (m_ph == 2'd2) begin
            m_ph = 2'd1; m_rnd = m_rnd + 4'd1; m_rem = m_len;
          end else if (m_rnd == 4'(Rounds)) begin
            m_ph = 2'd3; m_rem = 8'd0;
          end else begin
            m_ph = 2'd2; m_rem = 8'(RestS);
          end
        end
      end
    end else if (s && d != 8'd0) begin
      m_ph = 2'd1; m_rem = d; m_len = d; m_rnd = 4'd1; m_pau = 1'b0; m_beep = 1'b1;
      m_left = Tps - 1;  // the accepting cycle already counts
    end
  endtask

  // Drive one cycle, predict, then compare after the edge.
  task automatic cyc(input logic r, input logic s, input logic p, input logic a);
    rst = r; start = s; pause = p; abort = a; duration_in = cur_dur;
    model(r, s, p, a, cur_dur);
    exp_q.push_back({m_ph, m_rem, m_rnd, m_pau, m_beep});
    @(posedge clk);
    #1;
    cnum++;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard empty at cycle %0d", cnum);
    end else begin
      check($sformatf("cyc%0d", cnum), obs(), exp_q.pop_front());
    end
    rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  task automatic run_until(input int n);
    while (cnum < n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic spot(input string tag, input logic [1:0] ph, input logic [7:0] rem,
                      input logic [3:0] rnd, input logic pau, input logic bp);
    check(tag, obs(), {ph, rem, rnd, pau, bp});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; duration_in = 8'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    spot("reset", 2'd0, 8'd0, 4'd0, 1'b0, 1'b0);

    // Full session; duration_in changes mid-session and must not affect the reload.
    cnum = 0; cur_dur = 8'd3;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    spot("full_c1_work", 2'd1, 8'd3, 4'd1, 1'b0, 1'b1);
    run_until(5); cur_dur = 8'd9;
    run_until(12); spot("full_c12_rest", 2'd2, 8'd2, 4'd1, 1'b0, 1'b1);
    run_until(20); spot("full_c20_work2", 2'd1, 8'd3, 4'd2, 1'b0, 1'b1);
    run_until(32); spot("full_c32_done", 2'd3, 8'd0, 4'd2, 1'b0, 1'b1);
    run_until(34); spot("done_hold", 2'd3, 8'd0, 4'd2, 1'b0, 1'b0);

    // Zero duration start and pause in IDLE are ignored.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cur_dur = 8'd0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0); spot("zero_dur", 2'd0, 8'd0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0); spot("idle_pause", 2'd0, 8'd0, 4'd0, 1'b0, 1'b0);

    // Pause over cycles 7..16.
    cnum = 0; cur_dur = 8'd3;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_until(6); cyc(1'b0, 1'b0, 1'b1, 1'b0);
    spot("pause_c7", 2'd1, 8'd2, 4'd1, 1'b1, 1'b0);
    run_until(16); spot("pause_c16", 2'd1, 8'd2, 4'd1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0); spot("resume_c17", 2'd1, 8'd2, 4'd1, 1'b0, 1'b0);
    run_until(42); spot("pause_c42_done", 2'd3, 8'd0, 4'd2, 1'b0, 1'b1);

    // Abort mid-REST (start from DONE).
    cnum = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_until(14); spot("abort_c14_rest", 2'd2, 8'd2, 4'd1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1); spot("abort_c15_idle", 2'd0, 8'd0, 4'd0, 1'b0, 1'b0);

    // Simultaneous abort and start, then rst during WORK, then immediate restart.
    cyc(1'b0, 1'b1, 1'b0, 1'b1); spot("abort_start", 2'd0, 8'd0, 4'd0, 1'b0, 1'b0);
    cnum = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_until(5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0); spot("rst_in_work", 2'd0, 8'd0, 4'd0, 1'b0, 1'b0);
    cur_dur = 8'd5;
    cyc(1'b0, 1'b1, 1'b0, 1'b0); spot("start_after_rst", 2'd1, 8'd5, 4'd1, 1'b0, 1'b1);

    // Pause on the tick cycle suppresses that tick.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cnum = 0; cur_dur = 8'd2;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_until(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0); spot("pause_on_tick", 2'd1, 8'd2, 4'd1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    run_until(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interval_countdown.md
INTERVAL_COUNTDOWN -- requirements
Module: interval_countdown

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameter TICKS_PER_SEC, default 50_000_000, SHALL set the number of clk cycles per one-second tick; allowed values are 2 or more.
REQ-003 Parameter REST_SEC, default 10, SHALL set the rest-phase length in seconds; allowed range is 1..255.
REQ-004 Parameter ROUNDS, default 4, SHALL set the number of work phases per session; allowed range is 1..15.
REQ-005 clk  input  1  SHALL be the system clock; all logic is rising-edge.
REQ-006 rst  input  1  SHALL be the synchronous active-high reset.
REQ-007 duration_in  input  8  SHALL be the work length in seconds, taken unsigned from the upstream combinational_circuit T3 output.
REQ-008 start  input  1  SHALL be a single-cycle pulse that requests a session start.
REQ-009 pause  input  1  SHALL be a single-cycle pulse that toggles run/freeze.
REQ-010 abort  input  1  SHALL be a single-cycle pulse that cancels the session.
REQ-011 remaining  output  8  SHALL be the seconds left in the current phase.
REQ-012 phase  output  2  SHALL encode the phase: 0 IDLE, 1 WORK, 2 REST, 3 DONE.
REQ-013 round_cnt  output  4  SHALL be the current round, 1-based; it is 0 in IDLE.
REQ-014 paused  output  1  SHALL be high while the countdown is frozen.
REQ-015 beep  output  1  SHALL be a one-cycle pulse on every phase change other than abort.

Function
REQ-016 The state machine SHALL have the states IDLE, WORK, REST, and DONE, plus a paused flag that is valid in WORK and REST.
REQ-017 In IDLE or DONE, start with duration_in != 0 SHALL cause the block, on the next edge, to latch work_len = duration_in, set remaining = duration_in, round_cnt = 1, phase = WORK, clear the prescaler, and pulse beep.
REQ-018 start with duration_in == 0 SHALL be ignored; start in WORK or REST SHALL also be ignored.
REQ-019 The prescaler SHALL count 0..TICKS_PER_SEC-1 only while in WORK or REST and not paused; the terminal count is the tick.
REQ-020 The first tick SHALL occur TICKS_PER_SEC cycles after the start is accepted.
REQ-021 On a tick with remaining > 1, remaining SHALL decrement by 1.
REQ-022 On a tick with remaining == 1 in WORK: if round_cnt == ROUNDS, the block SHALL go to DONE with remaining = 0; otherwise it SHALL go to REST with remaining = REST_SEC. In both cases beep SHALL pulse.
REQ-023 On a tick with remaining == 1 in REST, the block SHALL go to WORK, increment round_cnt, reload remaining = work_len, and pulse beep.
REQ-024 A change of duration_in mid-session SHALL have no effect; only the latched work_len is used.
REQ-025 pause SHALL toggle paused in WORK or REST only; while paused, remaining and the prescaler SHALL hold; on resume, counting SHALL continue from the held prescaler value.
REQ-026 pause in IDLE or DONE SHALL be ignored.
REQ-027 abort in any state SHALL return the block to IDLE on the next edge, with remaining = 0, round_cnt = 0, paused = 0, and no beep.
REQ-028 Priority on simultaneous inputs SHALL be abort > pause > tick > start.
REQ-029 A pause arriving in the same cycle as a tick SHALL freeze the block and suppress that tick's decrement or transition.
REQ-030 DONE SHALL hold its outputs (phase = 3, remaining = 0, round_cnt = ROUNDS) until start or abort.

Reset
REQ-031 rst SHALL force IDLE, remaining = 0, round_cnt = 0, paused = 0, beep = 0, prescaler = 0, and work_len = 0, overriding all other inputs, including mid-session.
REQ-032 After rst deasserts, the block SHALL accept a start on the first following edge.

Structure
REQ-033 The shared package fitness_timer_pkg SHALL hold the phase encoding constants, the state typedef, and the 8-bit seconds width.
REQ-034 The prescaler SHALL be the sub-module tick_prescaler, with clk, rst, and enable inputs, a tick output, and the TICKS_PER_SEC parameter.
REQ-035 All outputs SHALL be registered.

Verification (TICKS_PER_SEC=4, REST_SEC=2, ROUNDS=2)
REQ-036 Full session: duration_in=3, start at cycle 0 -> WORK/remaining=3 at cycle 1; REST/remaining=2 at cycle 12; WORK/round_cnt=2/remaining=3 at cycle 20; DONE at cycle 32; beep pulses on exactly those four cycles.
REQ-037 Zero duration: duration_in=0, start -> the block stays in IDLE, with no beep and all outputs at 0.
REQ-038 Pause: pause pulse at cycle 6 and again at cycle 16 -> remaining stays at 2 over cycles 7..16, paused=1 over that span, and DONE is reached at cycle 42.
REQ-039 Abort mid-REST: abort at cycle 14 -> IDLE at cycle 15, remaining=0, round_cnt=0, no beep.
REQ-040 Same-cycle abort and start, and rst asserted during WORK -> IDLE with all reset values; a following start with duration_in=5 gives remaining=5.
REQ-041 duration_in changed to 9 during WORK -> the reload after REST still uses the latched value 3.
